// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbitration bundle: IF-stage fetch address, loader session signals
// and the shared single-port memory port. slave = arbiter side, master = surrounding system.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] if_addr;
    logic              fetch_stall;
    logic              pc_restart;

    logic              ld_req;
    logic              ld_ack;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [ADDR_W:0]   ld_words;
    logic              ld_timeout;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  if_addr, ld_req, ld_we, ld_addr, ld_wdata,
        output fetch_stall, pc_restart, ld_ack, ld_words, ld_timeout,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_addr, ld_req, ld_we, ld_addr, ld_wdata,
        input  fetch_stall, pc_restart, ld_ack, ld_words, ld_timeout,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the instruction ROM port between fetch and a program loader: stall, drain, load, restart.
// Optional macro LOAD_TIMEOUT_EN aborts a LOAD session after TIMEOUT_CYCLES idle cycles.
module imem_arbiter #(
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DRAIN_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);

    localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RESTART = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [ADDR_W:0]    words_q;
    logic               timeout_q;
    logic               tmo_hit;
    logic               wait_low;
    logic               drain_done;
    logic               load_entry;

    assign drain_done = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));
    assign load_entry = (state == DRAIN) && (state_nxt == LOAD);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and port mux, decoded from the registered state
    always_comb begin
        state_nxt       = state;
        bus.fetch_stall = 1'b0;
        bus.pc_restart  = 1'b0;
        bus.ld_ack      = 1'b0;
        bus.mem_en      = 1'b1;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = bus.if_addr;
        bus.mem_wdata   = '0;
        case (state)
            RUN: begin
                if (bus.ld_req && !wait_low) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                bus.fetch_stall = 1'b1;
                bus.mem_en      = 1'b0;
                if (!bus.ld_req) begin
                    state_nxt = RUN;
                end else if (drain_done) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                bus.ld_ack      = 1'b1;
                bus.fetch_stall = 1'b1;
                bus.mem_en      = bus.ld_we;
                bus.mem_we      = bus.ld_we;
                bus.mem_addr    = bus.ld_addr;
                bus.mem_wdata   = bus.ld_wdata;
                if (!bus.ld_req || tmo_hit) begin
                    state_nxt = RESTART;
                end
            end
            RESTART: begin
                bus.pc_restart  = 1'b1;
                bus.fetch_stall = 1'b1;
                bus.mem_en      = 1'b0;
                state_nxt       = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Drain counter runs only while in DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // Session word count, saturating at the full address space
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
        end else if (load_entry) begin
            words_q <= '0;
        end else if ((state == LOAD) && bus.ld_we && (words_q != WORDS_MAX)) begin
            words_q <= words_q + (ADDR_W + 1)'(1);
        end
    end

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             wait_low_q;

    // A normal ld_req drop takes priority over a coincident timeout
    assign tmo_hit  = (state == LOAD) && bus.ld_req && !bus.ld_we &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign wait_low = wait_low_q;

    // Consecutive idle cycles inside LOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state != LOAD) || bus.ld_we) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Sticky timeout flag and the "ld_req must be seen low" re-arm guard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q  <= 1'b0;
            wait_low_q <= 1'b0;
        end else begin
            if (load_entry) begin
                timeout_q <= 1'b0;
            end else if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
            if (tmo_hit) begin
                wait_low_q <= 1'b1;
            end else if (!bus.ld_req) begin
                wait_low_q <= 1'b0;
            end
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign wait_low   = 1'b0;
    assign timeout_q  = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    assign bus.ld_words   = words_q;
    assign bus.ld_timeout = timeout_q;

endmodule
